wb_regfile: RTL and testbench

Architectural register file for the three-stage datapath, sitting at the write-back end of the stage-3 pipeline register. It accepts the stage-3 result (ALU output, write select, write enable) and commits it into a 32 x 32-bit array. It serves two combinational read ports to decode, with same-cycle write-through bypass. A per-register pending-write scoreboard raises `Stall` when decode reads a register whose producer has not yet reached write-back.

---
 rtl/wb_regfile_if.sv | 36 +++
 rtl/wb_regfile.sv | 89 ++++++++
 tb/tb_wb_regfile.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Bus bundle between the stage-3 write-back / decode logic and the register file.
// The master side is the pipeline; the slave side is wb_regfile.
interface wb_regfile_if #(
    parameter int NREG = 32,
    parameter int DW   = 32
);
    localparam int SW = $clog2(NREG);

    logic [DW-1:0] ALUOUT;
    logic [SW-1:0] S3_WriteSelect;
    logic          S3_WriteEnable;
    logic [SW-1:0] ReadSelect1;
    logic [SW-1:0] ReadSelect2;
    logic          ReadEnable1;
    logic          ReadEnable2;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;
    logic [SW-1:0] IssueSelect;
    logic          IssueEnable;
    logic          Stall;
    logic          Error;

    modport master (
        output ALUOUT, S3_WriteSelect, S3_WriteEnable,
        output ReadSelect1, ReadSelect2, ReadEnable1, ReadEnable2,
        output IssueSelect, IssueEnable,
        input  ReadData1, ReadData2, Stall, Error
    );

    modport slave (
        input  ALUOUT, S3_WriteSelect, S3_WriteEnable,
        input  ReadSelect1, ReadSelect2, ReadEnable1, ReadEnable2,
        input  IssueSelect, IssueEnable,
        output ReadData1, ReadData2, Stall, Error
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back register file: 32x32 array, two bypassed read ports and a
// per-register pending-write scoreboard that stalls decode on RAW hazards.
module wb_regfile #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);
    localparam int SW = $clog2(NREG);

    logic [DW-1:0] regs [NREG];
    logic [1:0]    cnt  [NREG];
    logic          error_q;

    logic dec;
    logic inc;
    logic same;
    logic hazard1;
    logic hazard2;
    logic stall;
    logic overflow;
    logic underflow;

    // A source with one producer in flight is released in the cycle that
    // producer writes back, since the bypass then supplies its data.
    always_comb begin
        dec     = 1'b0;
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        stall   = 1'b0;
        inc     = 1'b0;
        dec     = bus.S3_WriteEnable && (bus.S3_WriteSelect != '0);
        hazard1 = bus.ReadEnable1 && (bus.ReadSelect1 != '0) &&
                  ((cnt[bus.ReadSelect1] >= 2'd2) ||
                   ((cnt[bus.ReadSelect1] == 2'd1) &&
                    !(dec && (bus.S3_WriteSelect == bus.ReadSelect1))));
        hazard2 = bus.ReadEnable2 && (bus.ReadSelect2 != '0) &&
                  ((cnt[bus.ReadSelect2] >= 2'd2) ||
                   ((cnt[bus.ReadSelect2] == 2'd1) &&
                    !(dec && (bus.S3_WriteSelect == bus.ReadSelect2))));
        stall   = hazard1 || hazard2;
        inc     = bus.IssueEnable && !stall && (bus.IssueSelect != '0);
    end

    always_comb begin
        same      = inc && dec && (bus.IssueSelect == bus.S3_WriteSelect);
        overflow  = inc && !same && (cnt[bus.IssueSelect] == 2'd3);
        underflow = dec && !same && (cnt[bus.S3_WriteSelect] == 2'd0);
    end

    always_comb begin
        bus.ReadData1 = regs[bus.ReadSelect1];
        bus.ReadData2 = regs[bus.ReadSelect2];
        if (dec && (bus.S3_WriteSelect == bus.ReadSelect1)) begin
            bus.ReadData1 = bus.ALUOUT;
        end
        if (dec && (bus.S3_WriteSelect == bus.ReadSelect2)) begin
            bus.ReadData2 = bus.ALUOUT;
        end
        bus.Stall = stall;
        bus.Error = error_q;
    end

    // Counts saturate at both ends; the offending event is remembered in error_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            error_q <= 1'b0;
        end else begin
            if (dec) begin
                regs[bus.S3_WriteSelect] <= bus.ALUOUT;
            end
            if (inc && !same && (cnt[bus.IssueSelect] != 2'd3)) begin
                cnt[bus.IssueSelect] <= cnt[bus.IssueSelect] + 2'd1;
            end
            if (dec && !same && (cnt[bus.S3_WriteSelect] != 2'd0)) begin
                cnt[bus.S3_WriteSelect] <= cnt[bus.S3_WriteSelect] - 2'd1;
            end
            if (overflow || underflow) begin
                error_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: one table row per clock cycle, checked just
// before the rising edge, followed by an asynchronous mid-cycle reset sequence.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst = 1'b0;

    wb_regfile_if #(.NREG(32), .DW(32)) bus ();

    wb_regfile #(.NREG(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] alu;
        logic [4:0]  wsel;
        logic        wen;
        logic [4:0]  rs1;
        logic        re1;
        logic [4:0]  rs2;
        logic        re2;
        logic [4:0]  isel;
        logic        ien;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
        logic        exp_stall;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 30;
    vec_t vecs [NVEC];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    function automatic vec_t mk(input logic r, input logic [31:0] alu, input logic [4:0] wsel,
                                input logic wen, input logic [4:0] rs1, input logic re1,
                                input logic [4:0] rs2, input logic re2, input logic [4:0] isel,
                                input logic ien, input logic [31:0] erd1, input logic [31:0] erd2,
                                input logic estall, input logic eerr);
        vec_t v;
        v.rst = r;        v.alu = alu;      v.wsel = wsel;     v.wen = wen;
        v.rs1 = rs1;      v.re1 = re1;      v.rs2 = rs2;       v.re2 = re2;
        v.isel = isel;    v.ien = ien;
        v.exp_rd1 = erd1; v.exp_rd2 = erd2; v.exp_stall = estall; v.exp_err = eerr;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst                = v.rst;
        bus.ALUOUT         = v.alu;
        bus.S3_WriteSelect = v.wsel;
        bus.S3_WriteEnable = v.wen;
        bus.ReadSelect1    = v.rs1;
        bus.ReadEnable1    = v.re1;
        bus.ReadSelect2    = v.rs2;
        bus.ReadEnable2    = v.re2;
        bus.IssueSelect    = v.isel;
        bus.IssueEnable    = v.ien;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic checkRow(input int idx, input vec_t v);
        checkOutput("ReadData1", idx, bus.ReadData1, v.exp_rd1);
        checkOutput("ReadData2", idx, bus.ReadData2, v.exp_rd2);
        checkOutput("Stall", idx, {31'd0, bus.Stall}, {31'd0, v.exp_stall});
        checkOutput("Error", idx, {31'd0, bus.Error}, {31'd0, v.exp_err});
    endtask

    initial begin
        //            rst alu           wsel wen rs1 re1 rs2 re2 isel ien rd1           rd2           stl err
        vecs[0]  = mk(1, 32'h0,         0,  0,  5, 1,  0, 0,  0, 0, 32'h0,        32'h0,        0, 0);
        vecs[1]  = mk(0, 32'hDEADBEEF,  0,  1,  0, 1,  0, 0,  0, 0, 32'h0,        32'h0,        0, 0);
        vecs[2]  = mk(0, 32'h0,         0,  0,  0, 1,  0, 0,  5, 1, 32'h0,        32'h0,        0, 0);
        vecs[3]  = mk(0, 32'h12345678,  5,  1,  5, 1,  6, 1,  0, 0, 32'h12345678, 32'h0,        0, 0);
        vecs[4]  = mk(0, 32'h0,         0,  0,  5, 1,  6, 1,  0, 0, 32'h12345678, 32'h0,        0, 0);
        vecs[5]  = mk(0, 32'h0,         0,  0,  5, 0,  0, 0,  7, 1, 32'h12345678, 32'h0,        0, 0);
        vecs[6]  = mk(0, 32'h0,         0,  0,  7, 1,  0, 0,  8, 1, 32'h0,        32'h0,        1, 0);
        vecs[7]  = mk(0, 32'h0,         0,  0,  7, 0,  8, 1,  0, 0, 32'h0,        32'h0,        0, 0);
        vecs[8]  = mk(0, 32'hA5A5A5A5,  7,  1,  7, 1,  0, 0,  0, 0, 32'hA5A5A5A5, 32'h0,        0, 0);
        vecs[9]  = mk(0, 32'h0,         0,  0,  7, 1,  0, 0,  0, 0, 32'hA5A5A5A5, 32'h0,        0, 0);
        vecs[10] = mk(0, 32'h0,         0,  0,  0, 0,  0, 0,  3, 1, 32'h0,        32'h0,        0, 0);
        vecs[11] = mk(0, 32'h33,        3,  1,  3, 1,  0, 0,  3, 1, 32'h33,       32'h0,        0, 0);
        vecs[12] = mk(0, 32'h0,         0,  0,  3, 1,  0, 0,  0, 0, 32'h33,       32'h0,        1, 0);
        vecs[13] = mk(0, 32'h44,        3,  1,  3, 1,  0, 0,  0, 0, 32'h44,       32'h0,        0, 0);
        vecs[14] = mk(0, 32'h0,         0,  0,  3, 1,  0, 0,  0, 0, 32'h44,       32'h0,        0, 0);
        for (int i = 15; i < 19; i++) begin
            vecs[i] = mk(0, 32'h0,      0,  0,  0, 0,  0, 0,  9, 1, 32'h0,        32'h0,        0, 0);
        end
        vecs[19] = mk(0, 32'h0,         0,  0,  9, 1,  0, 0,  0, 0, 32'h0,        32'h0,        1, 1);
        vecs[20] = mk(0, 32'h99,        9,  1,  9, 1,  0, 0,  0, 0, 32'h99,       32'h0,        1, 1);
        vecs[21] = mk(1, 32'h0,         0,  0,  9, 1,  5, 1,  0, 0, 32'h0,        32'h0,        0, 0);
        vecs[22] = mk(0, 32'h1,         9,  1,  9, 1,  0, 0,  0, 0, 32'h1,        32'h0,        0, 0);
        vecs[23] = mk(0, 32'h0,         0,  0,  9, 1,  0, 0,  0, 0, 32'h1,        32'h0,        0, 1);
        vecs[24] = mk(1, 32'h0,         0,  0,  9, 1,  0, 0,  0, 0, 32'h0,        32'h0,        0, 0);
        vecs[25] = mk(0, 32'h0,         0,  0,  0, 0,  0, 0, 10, 1, 32'h0,        32'h0,        0, 0);
        vecs[26] = mk(0, 32'h0,         0,  0,  0, 0,  0, 0, 10, 1, 32'h0,        32'h0,        0, 0);
        vecs[27] = mk(0, 32'hA1,       10,  1,  0, 0, 10, 1,  0, 0, 32'h0,        32'hA1,       1, 0);
        vecs[28] = mk(0, 32'hA2,       10,  1, 10, 1, 10, 1,  0, 0, 32'hA2,       32'hA2,       0, 0);
        vecs[29] = mk(0, 32'h0,         0,  0, 10, 1,  0, 0,  0, 0, 32'hA2,       32'h0,        0, 0);

        applyStimulus(mk(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0));
        #1;
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkRow(i, vecs[i]);
            @(negedge clk);
        end

        // Issue r4, then pull reset between edges: the hazard must vanish at once.
        applyStimulus(mk(0, 32'h0, 0, 0, 0, 0, 0, 0, 4, 1, 32'h0, 32'h0, 0, 0));
        @(negedge clk);
        applyStimulus(mk(0, 32'h0, 0, 0, 4, 1, 10, 1, 0, 0, 32'h0, 32'h0, 0, 0));
        #1;
        checkOutput("midrst_stall_before", 100, {31'd0, bus.Stall}, 32'd1);
        checkOutput("midrst_rd2_before", 100, bus.ReadData2, 32'hA2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_stall_async", 101, {31'd0, bus.Stall}, 32'd0);
        checkOutput("midrst_rd1_async", 101, bus.ReadData1, 32'h0);
        checkOutput("midrst_rd2_async", 101, bus.ReadData2, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_stall_after", 102, {31'd0, bus.Stall}, 32'd0);
        checkOutput("midrst_error_after", 102, {31'd0, bus.Error}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
